// File: rtl/accum_pkg.sv
// Shared types and arithmetic helpers for the accumulator bank.
// Helpers work on a fixed wide datapath so any ACC_W/DATA_W up to 62 bits fits.
package accum_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } state_t;

  localparam int CALC_W = 64;

  typedef struct packed {
    logic [CALC_W-1:0] sum;
    logic              ovf;
  } sat_res_t;

  // Sign-extend the low w bits of v to the full working width.
  function automatic logic [CALC_W-1:0] sext(input logic [CALC_W-1:0] v, input int w);
    logic signed [CALC_W-1:0] t;
    t = $signed(v << (CALC_W - w));
    return t >>> (CALC_W - w);
  endfunction

  // a and b arrive sign-extended; the result is an acc_w-bit value, sign-extended.
  function automatic sat_res_t sat_add(input logic [CALC_W-1:0] a,
                                       input logic [CALC_W-1:0] b,
                                       input int                acc_w,
                                       input bit                saturate);
    logic signed [CALC_W-1:0] full;
    logic signed [CALC_W-1:0] hi;
    logic signed [CALC_W-1:0] lo;
    sat_res_t r;
    full  = $signed(a) + $signed(b);
    hi    = (64'sd1 <<< (acc_w - 1)) - 64'sd1;
    lo    = -(64'sd1 <<< (acc_w - 1));
    r.ovf = (full > hi) || (full < lo);
    if (saturate && r.ovf) r.sum = (full > hi) ? hi : lo;
    else                   r.sum = sext(full, acc_w);
    return r;
  endfunction

endpackage

// File: rtl/accum_lane.sv
// One accumulator lane: sum/tag/occupancy/saturation state with tag compare,
// saturating adder and load/clear/drain muxing.
module accum_lane
  import accum_pkg::*;
#(
  parameter int DATA_W   = 17,
  parameter int ACC_W    = 24,
  parameter int ADDR_W   = 27,
  parameter int SATURATE = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clear,
  input  logic              i_load,
  input  logic [ACC_W-1:0]  i_load_sum,
  input  logic [ADDR_W-1:0] i_load_tag,
  input  logic              i_load_occ,
  input  logic              i_acc,
  input  logic [DATA_W-1:0] i_data,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic              i_drain_clr,
  output logic [ACC_W-1:0]  o_sum,
  output logic [ADDR_W-1:0] o_tag,
  output logic              o_occ,
  output logic              o_sat,
  output logic              o_conflict
);

  logic [ACC_W-1:0]  r_sum;
  logic [ADDR_W-1:0] r_tag;
  logic              r_occ;
  logic              r_sat;
  logic              r_conflict;
  logic [CALC_W-1:0] w_data_ext;
  sat_res_t          w_res;
  logic              w_tag_hit;

  assign w_tag_hit  = (r_tag == i_addr);
  assign w_data_ext = sext(CALC_W'(i_data), DATA_W);
  assign w_res      = sat_add(sext(CALC_W'(r_sum), ACC_W), w_data_ext, ACC_W, SATURATE != 0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sum      <= '0;
      r_tag      <= '0;
      r_occ      <= 1'b0;
      r_sat      <= 1'b0;
      r_conflict <= 1'b0;
    end else if (i_clear) begin
      r_sum      <= '0;
      r_tag      <= '0;
      r_occ      <= 1'b0;
      r_sat      <= 1'b0;
      r_conflict <= 1'b0;
    end else if (i_load) begin
      r_sum      <= i_load_sum;
      r_tag      <= i_load_tag;
      r_occ      <= i_load_occ;
      r_sat      <= 1'b0;
      r_conflict <= 1'b0;
    end else begin
      // conflict is a single-cycle pulse, so it falls unless re-raised below
      r_conflict <= 1'b0;
      if (i_drain_clr) begin
        r_sum <= '0;
        r_tag <= '0;
        r_occ <= 1'b0;
        r_sat <= 1'b0;
      end else if (i_acc) begin
        if (!r_occ) begin
          r_sum <= ACC_W'(w_data_ext);
          r_tag <= i_addr;
          r_occ <= 1'b1;
        end else if (w_tag_hit) begin
          r_sum <= ACC_W'(w_res.sum);
          if ((SATURATE != 0) && w_res.ovf) r_sat <= 1'b1;
        end else begin
          r_conflict <= 1'b1;
        end
      end
    end
  end

  assign o_sum      = r_sum;
  assign o_tag      = r_tag;
  assign o_occ      = r_occ;
  assign o_sat      = r_sat;
  assign o_conflict = r_conflict;

endmodule

// File: rtl/accum_bank.sv
// Bank of tagged accumulator lanes with bulk load from BRAM and a scan FSM
// that drains occupied lanes back one per valid/ready handshake.
module accum_bank
  import accum_pkg::*;
#(
  parameter int LANES    = 16,
  parameter int DATA_W   = 17,
  parameter int ACC_W    = 24,
  parameter int ADDR_W   = 27,
  parameter int SATURATE = 1,
  parameter int PTR_W    = $clog2(LANES)
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic                            clear,
  input  logic                            enable,
  input  logic [LANES-1:0]                in_valid,
  input  logic [LANES-1:0]                lane_mask,
  input  logic [LANES*DATA_W-1:0]         in_data,
  input  logic [LANES*ADDR_W-1:0]         in_addr,
  input  logic                            load_valid,
  output logic                            load_ready,
  input  logic [LANES*(ACC_W+ADDR_W)-1:0] load_data,
  input  logic [LANES-1:0]                load_occ,
  input  logic                            drain_start,
  output logic                            drain_valid,
  input  logic                            drain_ready,
  output logic [PTR_W-1:0]                drain_lane,
  output logic [ACC_W-1:0]                drain_data,
  output logic [ADDR_W-1:0]               drain_addr,
  output logic                            drain_last,
  output logic                            drain_done,
  output logic                            busy,
  output logic [LANES-1:0]                conflict,
  output logic [LANES-1:0]                sat_flag,
  output state_t                          o_dbg_state
);

  localparam int              SLOT_W   = ACC_W + ADDR_W;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(LANES - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [PTR_W-1:0]  r_ptr;
  logic [PTR_W-1:0]  w_ptr_nxt;
  logic              r_drain_done;
  logic              w_done_nxt;
  logic [LANES-1:0]  w_occ;
  logic [ACC_W-1:0]  w_sum [LANES];
  logic [ADDR_W-1:0] w_tag [LANES];
  logic              w_idle;
  logic              w_in_drain;
  logic              w_load_fire;
  logic              w_acc_ok;
  logic              w_drain_fire;
  logic              w_lane_done;

  // Handshakes: a transfer happens on a rising edge where valid and ready are
  // both high; drain_valid/drain_lane/data/addr stay stable until that edge.
  assign w_idle       = (r_state == IDLE);
  assign w_in_drain   = (r_state == DRAIN);
  assign load_ready   = w_idle & ~drain_start & ~clear;
  assign w_load_fire  = load_valid & load_ready;
  assign w_acc_ok     = load_ready & ~load_valid & enable;
  assign drain_valid  = w_in_drain & w_occ[r_ptr];
  assign w_drain_fire = drain_valid & drain_ready;
  assign w_lane_done  = w_in_drain & (~w_occ[r_ptr] | drain_ready);

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state      <= IDLE;
      r_ptr        <= '0;
      r_drain_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_ptr        <= w_ptr_nxt;
      r_drain_done <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_done_nxt  = 1'b0;
    if (clear) begin
      w_state_nxt = IDLE;
      w_ptr_nxt   = '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (drain_start) begin
            w_state_nxt = DRAIN;
            w_ptr_nxt   = '0;
          end
        end
        DRAIN: begin
          if (w_lane_done) begin
            if (r_ptr == LAST_PTR) begin
              w_state_nxt = IDLE;
              w_ptr_nxt   = '0;
              w_done_nxt  = 1'b1;
            end else begin
              w_ptr_nxt = r_ptr + 1'b1;
            end
          end
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    accum_lane #(
      .DATA_W  (DATA_W),
      .ACC_W   (ACC_W),
      .ADDR_W  (ADDR_W),
      .SATURATE(SATURATE)
    ) u_lane (
      .clk        (clock),
      .rst_n      (reset),
      .i_clear    (clear),
      .i_load     (w_load_fire),
      .i_load_sum (load_data[i*SLOT_W+ADDR_W +: ACC_W]),
      .i_load_tag (load_data[i*SLOT_W +: ADDR_W]),
      .i_load_occ (load_occ[i]),
      .i_acc      (w_acc_ok & in_valid[i] & lane_mask[i]),
      .i_data     (in_data[i*DATA_W +: DATA_W]),
      .i_addr     (in_addr[i*ADDR_W +: ADDR_W]),
      .i_drain_clr(w_drain_fire & (r_ptr == PTR_W'(i))),
      .o_sum      (w_sum[i]),
      .o_tag      (w_tag[i]),
      .o_occ      (w_occ[i]),
      .o_sat      (sat_flag[i]),
      .o_conflict (conflict[i])
    );
  end

  assign drain_lane  = r_ptr;
  assign drain_data  = w_sum[r_ptr];
  assign drain_addr  = w_tag[r_ptr];
  assign drain_last  = w_in_drain & (r_ptr == LAST_PTR);
  assign drain_done  = r_drain_done;
  assign busy        = ~w_idle;
  assign o_dbg_state = r_state;

endmodule

// File: tb/tb_accum_bank.sv
// Bench for accum_bank: a saturating and a wrapping instance share all inputs;
// a reference model fills the expected drain queue, drain outputs are popped and compared.
module tb_accum_bank;
  import accum_pkg::*;

  localparam int LANES  = 4;
  localparam int DATA_W = 17;
  localparam int ACC_W  = 24;
  localparam int ADDR_W = 27;
  localparam int PTR_W  = $clog2(LANES);
  localparam int SLOT_W = ACC_W + ADDR_W;
  localparam int QW     = PTR_W + 2*ACC_W + ADDR_W;
  localparam longint MAXV = (64'sd1 <<< (ACC_W-1)) - 64'sd1;
  localparam longint MINV = -(64'sd1 <<< (ACC_W-1));

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset = 1'b0;
  always #5 clock = ~clock;

  logic                     clear = 1'b0;
  logic                     enable = 1'b0;
  logic [LANES-1:0]         in_valid = '0;
  logic [LANES-1:0]         lane_mask = '0;
  logic [LANES*DATA_W-1:0]  in_data = '0;
  logic [LANES*ADDR_W-1:0]  in_addr = '0;
  logic                     load_valid = 1'b0;
  logic [LANES*SLOT_W-1:0]  load_data = '0;
  logic [LANES-1:0]         load_occ = '0;
  logic                     drain_start = 1'b0;
  logic                     drain_ready = 1'b0;

  logic load_ready_s, drain_valid_s, drain_last_s, drain_done_s, busy_s;
  logic [PTR_W-1:0] drain_lane_s;
  logic [ACC_W-1:0] drain_data_s;
  logic [ADDR_W-1:0] drain_addr_s;
  logic [LANES-1:0] conflict_s, sat_flag_s;
  state_t state_s;

  logic load_ready_w, drain_valid_w, drain_last_w, drain_done_w, busy_w;
  logic [PTR_W-1:0] drain_lane_w;
  logic [ACC_W-1:0] drain_data_w;
  logic [ADDR_W-1:0] drain_addr_w;
  logic [LANES-1:0] conflict_w, sat_flag_w;
  state_t state_w;

  accum_bank #(.LANES(LANES), .DATA_W(DATA_W), .ACC_W(ACC_W), .ADDR_W(ADDR_W), .SATURATE(1)) u_sat (
    .clock(clock), .reset(reset), .clear(clear), .enable(enable),
    .in_valid(in_valid), .lane_mask(lane_mask), .in_data(in_data), .in_addr(in_addr),
    .load_valid(load_valid), .load_ready(load_ready_s), .load_data(load_data), .load_occ(load_occ),
    .drain_start(drain_start), .drain_valid(drain_valid_s), .drain_ready(drain_ready),
    .drain_lane(drain_lane_s), .drain_data(drain_data_s), .drain_addr(drain_addr_s),
    .drain_last(drain_last_s), .drain_done(drain_done_s), .busy(busy_s),
    .conflict(conflict_s), .sat_flag(sat_flag_s), .o_dbg_state(state_s)
  );

  accum_bank #(.LANES(LANES), .DATA_W(DATA_W), .ACC_W(ACC_W), .ADDR_W(ADDR_W), .SATURATE(0)) u_wrap (
    .clock(clock), .reset(reset), .clear(clear), .enable(enable),
    .in_valid(in_valid), .lane_mask(lane_mask), .in_data(in_data), .in_addr(in_addr),
    .load_valid(load_valid), .load_ready(load_ready_w), .load_data(load_data), .load_occ(load_occ),
    .drain_start(drain_start), .drain_valid(drain_valid_w), .drain_ready(drain_ready),
    .drain_lane(drain_lane_w), .drain_data(drain_data_w), .drain_addr(drain_addr_w),
    .drain_last(drain_last_w), .drain_done(drain_done_w), .busy(busy_w),
    .conflict(conflict_w), .sat_flag(sat_flag_w), .o_dbg_state(state_w)
  );

  // ---------------- model + scoreboard ----------------
  logic              m_occ   [LANES];
  logic [ADDR_W-1:0] m_tag   [LANES];
  longint            m_sum_s [LANES];
  longint            m_sum_w [LANES];
  logic [LANES-1:0]  m_sat;
  logic [QW-1:0]     exp_q[$];

  logic [DATA_W-1:0] d_data [LANES];
  logic [ADDR_W-1:0] d_addr [LANES];
  logic [ACC_W-1:0]  l_sum  [LANES];
  logic [ADDR_W-1:0] l_tag  [LANES];

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic model_clear();
    for (int i = 0; i < LANES; i++) begin
      m_occ[i] = 1'b0; m_tag[i] = '0; m_sum_s[i] = 0; m_sum_w[i] = 0;
    end
    m_sat = '0;
  endtask

  task automatic model_acc(input int i, inout logic [LANES-1:0] conf);
    longint d, f;
    logic [ACC_W-1:0] t;
    d = longint'($signed(d_data[i]));
    if (!m_occ[i]) begin
      m_occ[i] = 1'b1; m_tag[i] = d_addr[i]; m_sum_s[i] = d; m_sum_w[i] = d;
    end else if (m_tag[i] == d_addr[i]) begin
      f = m_sum_s[i] + d;
      if (f > MAXV) begin f = MAXV; m_sat[i] = 1'b1; end
      else if (f < MINV) begin f = MINV; m_sat[i] = 1'b1; end
      m_sum_s[i] = f;
      f = m_sum_w[i] + d;
      t = f[ACC_W-1:0];
      m_sum_w[i] = longint'($signed(t));
    end else begin
      conf[i] = 1'b1;
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle_inputs();
    enable = 1'b0; in_valid = '0; lane_mask = '0;
    load_valid = 1'b0; load_occ = '0; drain_start = 1'b0; drain_ready = 1'b0;
  endtask

  task automatic drive_acc(input logic [LANES-1:0] v, input logic [LANES-1:0] m, input logic en);
    logic [LANES-1:0] exp_conf;
    exp_conf = '0;
    for (int i = 0; i < LANES; i++) begin
      in_data[i*DATA_W +: DATA_W] = d_data[i];
      in_addr[i*ADDR_W +: ADDR_W] = d_addr[i];
      if (en && v[i] && m[i]) model_acc(i, exp_conf);
    end
    in_valid = v; lane_mask = m; enable = en;
    tick();
    in_valid = '0; lane_mask = '0; enable = 1'b0;
    check_eq("conflict_s", 64'(conflict_s), 64'(exp_conf));
    check_eq("conflict_w", 64'(conflict_w), 64'(exp_conf));
    check_eq("sat_flag_s", 64'(sat_flag_s), 64'(m_sat));
    check_eq("sat_flag_w", 64'(sat_flag_w), 64'(0));
  endtask

  task automatic do_load(input logic [LANES-1:0] occ);
    for (int i = 0; i < LANES; i++) load_data[i*SLOT_W +: SLOT_W] = {l_sum[i], l_tag[i]};
    load_occ = occ; load_valid = 1'b1;
    #1;
    check_eq("load_ready", 64'(load_ready_s), 64'(1));
    tick();
    load_valid = 1'b0; load_occ = '0;
    for (int i = 0; i < LANES; i++) begin
      m_occ[i] = occ[i]; m_tag[i] = l_tag[i];
      m_sum_s[i] = longint'($signed(l_sum[i])); m_sum_w[i] = m_sum_s[i];
    end
    m_sat = '0;
    check_eq("load_sat", 64'(sat_flag_s), 64'(0));
    check_eq("load_conflict", 64'(conflict_s), 64'(0));
  endtask

  // Push expected items, run a drain while hammering load/accumulate inputs
  // (which must be ignored), and compare each presented lane against the queue.
  task automatic run_drain(input int stall_lane, input int stall_n);
    int cyc, done_cnt, done_at, stall;
    logic [QW-1:0] item;
    for (int i = 0; i < LANES; i++) begin
      if (m_occ[i]) exp_q.push_back({PTR_W'(i), ACC_W'(m_sum_s[i]), ACC_W'(m_sum_w[i]), m_tag[i]});
    end
    model_clear();
    drain_start = 1'b1;
    #1;
    check_eq("load_ready_ds", 64'(load_ready_s), 64'(0));
    tick();
    drain_start = 1'b0;
    check_eq("busy_drain", 64'(busy_s), 64'(1));
    check_eq("state_drain", 64'(state_s), 64'(DRAIN));
    load_data = '1; load_occ = '1; load_valid = 1'b1;
    in_data = '0; in_addr = '0; in_valid = '1; lane_mask = '1; enable = 1'b1;
    cyc = 0; done_cnt = 0; done_at = -1; stall = stall_n;
    while (cyc < 64) begin
      @(negedge clock);
      if (drain_done_s) begin
        done_cnt++; done_at = cyc;
        idle_inputs();
      end
      if (drain_valid_s) begin
        check_eq("load_ready_in_drain", 64'(load_ready_s), 64'(0));
        if (exp_q.size() == 0) begin
          check_eq("unexpected_valid", 64'(drain_valid_s), 64'(0));
          drain_ready = 1'b0;
        end else begin
          item = exp_q[0];
          check_eq("drain_lane", 64'(drain_lane_s), 64'(item[QW-1 -: PTR_W]));
          check_eq("drain_data_s", 64'(drain_data_s), 64'(item[2*ACC_W+ADDR_W-1 -: ACC_W]));
          check_eq("drain_data_w", 64'(drain_data_w), 64'(item[ACC_W+ADDR_W-1 -: ACC_W]));
          check_eq("drain_addr", 64'(drain_addr_s), 64'(item[ADDR_W-1:0]));
          check_eq("drain_last", 64'(drain_last_s), 64'(item[QW-1 -: PTR_W] == PTR_W'(LANES-1)));
          check_eq("drain_valid_w", 64'(drain_valid_w), 64'(1));
          if (int'(item[QW-1 -: PTR_W]) == stall_lane && stall > 0) begin
            drain_ready = 1'b0;
            stall--;
          end else begin
            drain_ready = 1'b1;
            void'(exp_q.pop_front());
          end
        end
      end else begin
        drain_ready = 1'($urandom_range(0, 1));
      end
      if (done_at >= 0 && cyc >= done_at + 1) break;
      @(posedge clock);
      cyc++;
    end
    idle_inputs();
    check_eq("done_count", 64'(done_cnt), 64'(1));
    check_eq("done_cycle", 64'(done_at), 64'(LANES + stall_n));
    check_eq("queue_left", 64'(exp_q.size()), 64'(0));
    check_eq("busy_after", 64'(busy_s), 64'(0));
    exp_q.delete();
    tick();
  endtask

  // Loads lanes 0 and 3, starts a drain and returns right after lane 0 is accepted.
  task automatic drain_past_lane0();
    d_data[0] = DATA_W'(11); d_addr[0] = ADDR_W'(32'h300);
    d_data[3] = DATA_W'(22); d_addr[3] = ADDR_W'(32'h303);
    drive_acc(4'b1001, '1, 1'b1);
    drain_start = 1'b1;
    tick();
    drain_start = 1'b0; drain_ready = 1'b1;
    @(negedge clock);
    check_eq("abort_pre_valid", 64'(drain_valid_s), 64'(1));
    check_eq("abort_pre_data", 64'(drain_data_s), 64'(11));
    @(posedge clock);
  endtask

  task automatic watch_no_done(input string tag);
    int n;
    n = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      if (drain_done_s || drain_done_w) n++;
    end
    check_eq(tag, 64'(n), 64'(0));
    check_eq({tag, "_busy"}, 64'(busy_s), 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    model_clear();
    for (int i = 0; i < LANES; i++) begin d_data[i] = '0; d_addr[i] = '0; l_sum[i] = '0; l_tag[i] = '0; end

    // reset state
    repeat (2) @(negedge clock);
    check_eq("rst_busy", 64'(busy_s), 64'(0));
    check_eq("rst_done", 64'(drain_done_s), 64'(0));
    reset = 1'b1;
    tick();
    check_eq("idle_busy", 64'(busy_s), 64'(0));
    check_eq("idle_load_ready", 64'(load_ready_s), 64'(1));
    check_eq("idle_valid", 64'(drain_valid_s), 64'(0));
    check_eq("idle_conflict", 64'(conflict_s), 64'(0));
    check_eq("idle_sat", 64'(sat_flag_s), 64'(0));
    check_eq("idle_state", 64'(state_s), 64'(IDLE));
    run_drain(-1, 0);

    // lane 2: +5 +7 -3 at tag 0x100
    d_addr[2] = ADDR_W'(32'h100);
    d_data[2] = DATA_W'(5);  drive_acc(4'b0100, '1, 1'b1);
    d_data[2] = DATA_W'(7);  drive_acc(4'b0100, '1, 1'b1);
    d_data[2] = DATA_W'(-3); drive_acc(4'b0100, '1, 1'b1);
    run_drain(-1, 0);
    run_drain(-1, 0);

    // enable low and masked lane must be ignored
    d_data[1] = DATA_W'(50); d_addr[1] = ADDR_W'(32'h5);
    drive_acc(4'b0010, '1, 1'b0);
    drive_acc(4'b0010, 4'b1101, 1'b1);

    // tag conflict on lane 1
    d_data[1] = DATA_W'(3); d_addr[1] = ADDR_W'(32'h10); drive_acc(4'b0010, '1, 1'b1);
    d_data[1] = DATA_W'(4); d_addr[1] = ADDR_W'(32'h11); drive_acc(4'b0010, '1, 1'b1);
    tick();
    check_eq("conflict_pulse_end", 64'(conflict_s), 64'(0));
    d_data[1] = DATA_W'(6); d_addr[1] = ADDR_W'(32'h10); drive_acc(4'b0010, '1, 1'b1);
    run_drain(-1, 0);

    // saturation: positive on lane 0, negative on lane 1
    l_sum[0] = ACC_W'(32'h7FFFF0); l_tag[0] = '0;
    l_sum[1] = ACC_W'(32'h800005); l_tag[1] = ADDR_W'(32'h7);
    l_sum[2] = ACC_W'(32'h123);    l_tag[2] = ADDR_W'(32'h9);
    do_load(4'b0011);
    d_data[0] = DATA_W'(32'h20);  d_addr[0] = '0;
    d_data[1] = DATA_W'(-16);     d_addr[1] = ADDR_W'(32'h7);
    drive_acc(4'b0011, '1, 1'b1);
    run_drain(-1, 0);
    check_eq("sat_cleared", 64'(sat_flag_s), 64'(0));

    // back-pressure on lane 0, last lane presented afterwards
    d_data[0] = DATA_W'(100);  d_addr[0] = ADDR_W'(32'h40);
    d_data[3] = DATA_W'(-200); d_addr[3] = ADDR_W'(32'h43);
    drive_acc(4'b1001, '1, 1'b1);
    run_drain(0, 3);
    run_drain(-1, 0);

    // random accumulate traffic
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 12; c++) begin
        for (int i = 0; i < LANES; i++) begin
          d_data[i] = DATA_W'($urandom_range(0, (1 << DATA_W) - 1));
          d_addr[i] = ($urandom_range(0, 7) == 0) ? ADDR_W'(32'h281 + i) : ADDR_W'(32'h280 + i);
        end
        drive_acc(LANES'($urandom_range(0, (1 << LANES) - 1)),
                  LANES'($urandom_range(0, (1 << LANES) - 1)),
                  1'($urandom_range(0, 3) != 0));
      end
      run_drain(int'($urandom_range(0, LANES - 1)), int'($urandom_range(0, 2)) * 0);
    end

    // async reset in the middle of a drain
    drain_past_lane0();
    #3 reset = 1'b0;
    #1;
    check_eq("arst_busy", 64'(busy_s), 64'(0));
    check_eq("arst_valid", 64'(drain_valid_s), 64'(0));
    check_eq("arst_data", 64'(drain_data_s), 64'(0));
    check_eq("arst_state", 64'(state_s), 64'(IDLE));
    @(negedge clock);
    reset = 1'b1; drain_ready = 1'b0;
    watch_no_done("arst_no_done");
    model_clear();
    run_drain(-1, 0);

    // synchronous clear in the middle of a drain
    drain_past_lane0();
    #1 clear = 1'b1;
    check_eq("clr_load_ready", 64'(load_ready_s), 64'(0));
    tick();
    clear = 1'b0; drain_ready = 1'b0;
    check_eq("clr_busy", 64'(busy_s), 64'(0));
    check_eq("clr_valid", 64'(drain_valid_s), 64'(0));
    check_eq("clr_state", 64'(state_s), 64'(IDLE));
    watch_no_done("clr_no_done");
    model_clear();
    run_drain(-1, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
